// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with a 2-entry skid buffer.
// The downstream stage always reads out_data straight from the main register.
// in_ready depends only on the registered state, so backpressure never forms
// a combinational path from out_ready back to the upstream stage.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds its data stable while valid is high and ready
// is low.
module pipe_skid_reg #(
    parameter int              DATA_W   = 64,
    parameter logic [DATA_W-1:0] NOP_DATA = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt,
    input  logic              cnt_clr
);

    // The encoding equals the number of held entries, so the state doubles
    // as the occupancy output.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_fire;
    logic              out_fire;
    logic              starved;

    assign in_ready   = (state_q != S_TWO);
    assign out_valid  = (state_q != S_EMPTY);
    assign out_data   = main_q;
    assign occupancy  = state_q;
    assign bubble_cnt = cnt_q;

    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = out_valid & out_ready;
    assign starved  = out_ready & ~out_valid & ~flush;

    // State and payload registers; reset drops every entry at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            main_q  <= NOP_DATA;
            skid_q  <= NOP_DATA;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next state and payload moves; flush wins over any transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = NOP_DATA;
            skid_d  = NOP_DATA;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = S_TWO;
                    end else if (out_fire) begin
                        main_d  = NOP_DATA;
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = NOP_DATA;
                        state_d = S_ONE;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    main_d  = NOP_DATA;
                    skid_d  = NOP_DATA;
                end
            endcase
        end
    end

    // Saturating count of cycles where the consumer was ready but starved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (starved && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed testbench for pipe_skid_reg: inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_pipe_skid_reg;

    localparam int          DATA_W = 16;
    localparam int          CNT_W  = 4;
    localparam logic [15:0] NOP    = 16'h0F0F;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  bubble_cnt;
    logic              cnt_clr;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(
        .DATA_W   (DATA_W),
        .NOP_DATA (NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt),
        .cnt_clr    (cnt_clr)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== NOP) begin errors++; $display("FAIL reset_out_data: got %h want %h", out_data, NOP); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        checks++; if (bubble_cnt !== 4'd0) begin errors++; $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt); end
    endtask

    task automatic test_stream;
        logic [15:0] vec [3];
        vec[0] = 16'h0011; vec[1] = 16'h0022; vec[2] = 16'h0033;
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = vec[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_data !== vec[i]) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, vec[i]); end
            checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL stream_occ[%0d]: got occ=%0d rdy=%b want occ=1 rdy=1", i, occupancy, in_ready); end
            if (i < 2) in_data = vec[i+1];
        end
        checks++; if (bubble_cnt !== 4'd1) begin errors++; $display("FAIL stream_bubble: got %0d want 1", bubble_cnt); end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== NOP) begin errors++; $display("FAIL stream_drain: got v=%b d=%h want v=0 d=%h", out_valid, out_data, NOP); end
    endtask

    task automatic test_skid;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00A1;
        @(negedge clk);
        checks++; if (occupancy !== 2'd1 || out_data !== 16'h00A1) begin errors++; $display("FAIL skid_one: got occ=%0d d=%h want occ=1 d=00a1", occupancy, out_data); end
        in_data = 16'h00A2;
        @(negedge clk);
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL skid_full: got occ=%0d rdy=%b want occ=2 rdy=0", occupancy, in_ready); end
        in_data = 16'h00A3;
        @(negedge clk);
        checks++; if (occupancy !== 2'd2 || out_data !== 16'h00A1) begin errors++; $display("FAIL skid_hold: got occ=%0d d=%h want occ=2 d=00a1", occupancy, out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_data !== 16'h00A2 || occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL skid_pop1: got d=%h occ=%0d rdy=%b want d=00a2 occ=1 rdy=1", out_data, occupancy, in_ready); end
        @(negedge clk);
        checks++; if (out_data !== 16'h00A3 || occupancy !== 2'd1) begin errors++; $display("FAIL skid_pop2: got d=%h occ=%0d want d=00a3 occ=1", out_data, occupancy); end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL skid_empty: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00B1;
        @(negedge clk);
        in_data = 16'h00B2;
        @(negedge clk);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_prefill: got occ=%0d want 2", occupancy); end
        flush = 1'b1; in_data = 16'h00B3;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== NOP) begin errors++; $display("FAIL flush_out: got v=%b d=%h want v=0 d=%h", out_valid, out_data, NOP); end
        checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got occ=%0d rdy=%b want occ=0 rdy=1", occupancy, in_ready); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== NOP) begin errors++; $display("FAIL flush_no_b3: got v=%b d=%h want v=0 d=%h", out_valid, out_data, NOP); end
    endtask

    task automatic test_simultaneous;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00C1;
        @(negedge clk);
        checks++; if (out_data !== 16'h00C1 || occupancy !== 2'd1) begin errors++; $display("FAIL simul_load: got d=%h occ=%0d want d=00c1 occ=1", out_data, occupancy); end
        in_data = 16'h00C2; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_data !== 16'h00C2 || occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL simul_swap: got d=%h occ=%0d rdy=%b want d=00c2 occ=1 rdy=1", out_data, occupancy, in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (occupancy !== 2'd0 || out_data !== NOP) begin errors++; $display("FAIL simul_drain: got occ=%0d d=%h want occ=0 d=%h", occupancy, out_data, NOP); end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00D1;
        @(negedge clk);
        in_data = 16'h00D2;
        @(negedge clk);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL areset_prefill: got occ=%0d want 2", occupancy); end
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL areset_state: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
        checks++; if (out_data !== NOP || in_ready !== 1'b1) begin errors++; $display("FAIL areset_data: got d=%h rdy=%b want d=%h rdy=1", out_data, in_ready, NOP); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_bubble_cnt;
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checks++; if (bubble_cnt !== 4'd0) begin errors++; $display("FAIL bubble_clr0: got %0d want 0", bubble_cnt); end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (bubble_cnt !== ((i > 15) ? 4'd15 : 4'(i))) begin
                errors++; $display("FAIL bubble_count[%0d]: got %0d want %0d", i, bubble_cnt, (i > 15) ? 15 : i);
            end
        end
        cnt_clr = 1'b1;
        @(negedge clk);
        checks++; if (bubble_cnt !== 4'd0) begin errors++; $display("FAIL bubble_clr_prio: got %0d want 0", bubble_cnt); end
        cnt_clr = 1'b0;
        @(negedge clk);
        checks++; if (bubble_cnt !== 4'd1) begin errors++; $display("FAIL bubble_restart: got %0d want 1", bubble_cnt); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (bubble_cnt !== 4'd1) begin errors++; $display("FAIL bubble_flush_hold: got %0d want 1", bubble_cnt); end
        out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bubble_cnt !== 4'd1) begin errors++; $display("FAIL bubble_not_ready: got %0d want 1", bubble_cnt); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_simultaneous();
        test_async_reset();
        test_bubble_cnt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised elastic pipeline register that sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It is the successor of the fixed-field stage register driven by a global stall vector.
- Uses a local valid/ready handshake with a 2-entry skid buffer, so backpressure never forms a combinational ready path across stages.
- Supports synchronous flush with bubble insertion.
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
DATA_W, 64, width of the packed stage payload (aluop, alusel, operands, waddr, we, link address, etc.).
NOP_DATA, 0, payload value loaded on reset, flush and when the register is empty; it must encode aluop/alusel NOP and we=disable.
CNT_W, 16, width of the bubble counter.

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
flush  in  1  synchronous flush; discards all held entries.
in_valid  in  1  upstream stage presents a payload.
in_ready  out  1  register can accept a payload; registered, not combinational from out_ready.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  out_data holds a valid payload.
out_ready  in  1  downstream stage accepts the payload.
out_data  out  DATA_W  payload to the downstream stage; driven directly from the main register.
occupancy  out  2  number of held entries (0, 1 or 2).
bubble_cnt  out  CNT_W  count of starved cycles.
cnt_clr  in  1  synchronous clear of bubble_cnt.

Behaviour:
- Storage and states:
  - Storage is a main register plus a skid register.
  - The state machine has three states: EMPTY (occupancy 0), ONE (main valid), TWO (main and skid valid).
- Derived signals:
  - in_fire = in_valid & in_ready & ~flush.
  - out_fire = out_valid & out_ready.
  - in_ready = (state != TWO).
  - out_valid = (state != EMPTY).
- Reset (rst=0, asynchronous):
  - state=EMPTY, main=skid=NOP_DATA, bubble_cnt=0.
  - Resulting outputs: in_ready=1, out_valid=0, out_data=NOP_DATA, occupancy=0.
  - Reset asserted mid-transfer drops all entries immediately, with no clock edge needed.
- Transitions (no flush):
  - EMPTY: in_fire loads main<=in_data and goes to ONE.
  - ONE, in_fire & out_fire: main<=in_data, stay ONE.
  - ONE, in_fire only: skid<=in_data, go to TWO.
  - ONE, out_fire only: main<=NOP_DATA, go to EMPTY.
  - TWO: in_ready=0. On out_fire: main<=skid, skid<=NOP_DATA, go to ONE.
  - Any other combination holds state and data unchanged.
- Latency and throughput:
  - Latency is 1 cycle: in_data accepted at edge N appears on out_data after edge N when the register was EMPTY, or ONE with a simultaneous out_fire.
  - Full throughput is 1 payload/cycle with no bubbles while out_ready=1.
- Ordering: FIFO order is always preserved. A skid entry is never overtaken by a new input, because in_ready=0 in TWO.
- Flush (highest priority after reset):
  - At the edge: state<=EMPTY, main<=NOP_DATA, skid<=NOP_DATA.
  - in_data offered in the flush cycle is not accepted (in_fire=0).
  - An out_fire in the flush cycle is a completed transfer for the consumer; the entry is simply not retained.
  - The cycle after a flush: in_ready=1, out_valid=0.
- NOP guarantee: whenever out_valid=0, out_data equals NOP_DATA, so legacy consumers that ignore out_valid still see a bubble.
- Bubble counter:
  - Increments when out_ready=1 & out_valid=0 & ~flush (downstream starved).
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr has priority over increment; the value reads 0 the next cycle.
- No X propagation: all registers have a reset value. in_data is sampled only on in_fire.

Test Plan:
1. Reset then stream: rst low 3 cycles, then release; out_ready=1; drive in_data=0x11,0x22,0x33 on consecutive cycles -> out_data shows 0x11,0x22,0x33 one cycle later each, occupancy stays 1, in_ready stays 1, bubble_cnt=1 (the first starved cycle before 0x11 arrives).
2. Backpressure/skid: out_ready=0, send 0xA1 then 0xA2 -> occupancy=2, in_ready=0 and 0xA3 held off by upstream; raise out_ready -> out_data 0xA1, 0xA2, 0xA3 in order with no loss or duplication.
3. Flush while full: occupancy=2 (0xB1,0xB2), assert flush with in_valid=1, in_data=0xB3 -> next cycle out_valid=0, out_data=NOP_DATA, occupancy=0, in_ready=1; 0xB3 is never output.
4. Async reset mid-operation: occupancy=2, pull rst low between clock edges -> out_valid=0, occupancy=0, out_data=NOP_DATA immediately (before the next edge).
5. Bubble counter saturation with CNT_W=4: in_valid=0, out_ready=1 for 20 cycles -> bubble_cnt=15 and holds; pulse cnt_clr -> 0 next cycle; cnt_clr and an increment condition in the same cycle -> 0.
6. Simultaneous in/out in ONE: main=0xC1, in_data=0xC2, in_valid=1, out_ready=1 -> after the edge out_data=0xC2, occupancy=1, skid unused.
